// File: rtl/reg_file_pkg.sv
// Shared register-file types: widths, address/value types and a one-hot decode helper.
package reg_file_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] reg_val_t;

  function automatic logic [NREGS-1:0] addr_onehot(input reg_addr_t addr);
    logic [NREGS-1:0] hot;
    hot       = '0;
    hot[addr] = 1'b1;
    return hot;
  endfunction

endpackage

// File: rtl/regfile_write_if.sv
// Write-back commit channel into the register file; write-back is the client, reg_file the server.
interface regfile_write_if;
  import reg_file_pkg::*;

  logic      en;
  reg_addr_t addr;
  reg_val_t  val;

  modport Server (input en, input addr, input val);
  modport Client (output en, output addr, output val);

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: flush/reset clear all, reserve beats a same-cycle release, x0 never busy.
module regfile_scoreboard
  import reg_file_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rsv_en,
  input  reg_addr_t        rsv_addr,
  input  logic             rel_en,
  input  reg_addr_t        rel_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] rsv_hot;
  logic [NREGS-1:0] rel_hot;

  always_comb begin
    rsv_hot   = rsv_en ? addr_onehot(rsv_addr) : '0;
    rel_hot   = rel_en ? addr_onehot(rel_addr) : '0;
    busy_next = busy_reg;
    if (flush) begin
      busy_next = '0;
    end else begin
      // Reserve is applied last so a new pending writer survives the old one's commit.
      busy_next = (busy_next & ~rel_hot) | rsv_hot;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy = busy_reg;

endmodule

// File: rtl/reg_file.sv
// Integer register file: one committed write, two registered reads, busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int XLEN  = reg_file_pkg::XLEN,
  parameter int NREGS = reg_file_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_if.Server       write0,
  input  reg_addr_t             rd0Addr,
  output reg_val_t              rd0Val,
  input  reg_addr_t             rd1Addr,
  output reg_val_t              rd1Val,
  input  logic                  rsvEn,
  input  reg_addr_t             rsvAddr,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy
);

  logic [XLEN-1:0] regs_reg [NREGS];
  logic            wr_commit;

  assign wr_commit = write0.en && (write0.addr != '0);

  // Reset wins over a same-cycle write; flush does not block the commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_commit) begin
      regs_reg[write0.addr] <= write0.val;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    reg_addr_t       addr;
    logic [XLEN-1:0] val_reg;

    assign addr = (gi == 0) ? rd0Addr : rd1Addr;

    always_ff @(posedge clk) begin
      if (rst) begin
        val_reg <= '0;
      end else if (addr == '0) begin
        val_reg <= '0;
`ifdef REGFILE_BYPASS_EN
      end else if (write0.en && (write0.addr == addr)) begin
        val_reg <= write0.val;
`endif
      end else begin
        val_reg <= regs_reg[addr];
      end
    end
  end

  assign rd0Val = g_rd[0].val_reg;
  assign rd1Val = g_rd[1].val_reg;

  // Release happens on the commit edge itself, so busy drops together with the array update.
  regfile_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (rsvEn),
    .rsv_addr (rsvAddr),
    .rel_en   (write0.en),
    .rel_addr (write0.addr),
    .flush    (flush),
    .busy     (busy)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against an array model.
module tb_reg_file;
  import reg_file_pkg::*;

  logic        clk;
  logic        rst;
  reg_addr_t   rd0Addr, rd1Addr, rsvAddr;
  reg_val_t    rd0Val, rd1Val;
  logic        rsvEn, flush;
  logic [31:0] busy;

  regfile_write_if wr ();

  reg_file dut (
    .clk     (clk),
    .rst     (rst),
    .write0  (wr),
    .rd0Addr (rd0Addr),
    .rd0Val  (rd0Val),
    .rd1Addr (rd1Addr),
    .rd1Val  (rd1Val),
    .rsvEn   (rsvEn),
    .rsvAddr (rsvAddr),
    .flush   (flush),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: architectural contents plus what each output should show next.
  logic [31:0] m_regs [32];
  logic [31:0] m_rd0, m_rd1, m_busy;

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wv);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == a) return wv;
`endif
    return m_regs[a];
  endfunction

  task automatic cycle(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wv,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic re, input logic [4:0] ra, input logic fl);
    rst = r; wr.en = we; wr.addr = wa; wr.val = wv;
    rd0Addr = a0; rd1Addr = a1; rsvEn = re; rsvAddr = ra; flush = fl;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_rd0 = 32'h0; m_rd1 = 32'h0; m_busy = 32'h0;
    end else begin
      m_rd0 = model_read(a0, we, wa, wv);
      m_rd1 = model_read(a1, we, wa, wv);
      if (we && wa != 0) m_regs[wa] = wv;
      if (fl) m_busy = 32'h0;
      else begin
        if (we) m_busy[wa] = 1'b0;
        if (re) m_busy[ra] = 1'b1;
      end
      m_busy[0] = 1'b0;
    end
    #1;
    $display("t=%0t rst=%0b we=%0b wa=%0d wv=%h rd0=x%0d rd1=x%0d rsv=%0b x%0d flush=%0b -> rd0Val=%h rd1Val=%h busy=%h",
             $time, r, we, wa, wv, a0, a1, re, ra, fl, rd0Val, rd1Val, busy);
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks += 3;
    if (rd0Val !== 32'h0) begin errors++; $display("FAIL reset_rd0 got %h want 0", rd0Val); end
    if (rd1Val !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h want 0", rd1Val); end
    if (busy !== 32'h0)   begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
    cycle(0, 0, 0, 0, 5, 0, 0, 0, 0);
    checks += 2;
    if (rd0Val !== 32'h0) begin errors++; $display("FAIL reset_read_x5 got %h want 0", rd0Val); end
    if (rd1Val !== 32'h0) begin errors++; $display("FAIL reset_read_x0 got %h want 0", rd1Val); end
  endtask

  task automatic test_write_read();
    cycle(0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 7, 7, 0, 0, 0);
    checks += 2;
    if (rd0Val !== 32'hDEADBEEF) begin errors++; $display("FAIL write_read_x7_p0 got %h want deadbeef", rd0Val); end
    if (rd1Val !== 32'hDEADBEEF) begin errors++; $display("FAIL write_read_x7_p1 got %h want deadbeef", rd1Val); end
    cycle(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 7, 0, 0, 0);
    checks += 1;
    if (rd0Val !== 32'h0) begin errors++; $display("FAIL write_x0_ignored got %h want 0", rd0Val); end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
    want = 32'hA5A5A5A5;
`else
    want = 32'h0;
`endif
    cycle(0, 1, 3, 32'hA5A5A5A5, 3, 3, 0, 0, 0);
    checks += 2;
    if (rd0Val !== want)   begin errors++; $display("FAIL same_cycle_read_x3 got %h want %h", rd0Val, want); end
    if (rd1Val !== rd0Val) begin errors++; $display("FAIL dual_port_agree got %h want %h", rd1Val, rd0Val); end
    cycle(0, 0, 0, 0, 3, 0, 0, 0, 0);
    checks += 1;
    if (rd0Val !== 32'hA5A5A5A5) begin errors++; $display("FAIL after_write_x3 got %h want a5a5a5a5", rd0Val); end
  endtask

  task automatic test_scoreboard();
    cycle(0, 0, 0, 0, 0, 0, 1, 9, 0);
    checks += 1;
    if (busy !== 32'h0000_0200) begin errors++; $display("FAIL reserve_x9 got %h want 00000200", busy); end
    cycle(0, 1, 9, 32'h99, 0, 0, 0, 0, 0);
    checks += 1;
    if (busy !== 32'h0) begin errors++; $display("FAIL release_x9 got %h want 0", busy); end
    cycle(0, 1, 9, 32'h98, 0, 0, 1, 9, 0);
    checks += 1;
    if (busy !== 32'h0000_0200) begin errors++; $display("FAIL reserve_beats_release got %h want 00000200", busy); end
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checks += 1;
    if (busy !== 32'h0000_0200) begin errors++; $display("FAIL reserve_x0_ignored got %h want 00000200", busy); end
  endtask

  task automatic test_flush();
    cycle(0, 0, 0, 0, 0, 0, 1, 2, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 4, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 6, 0);
    checks += 1;
    if (busy !== 32'h0000_0254) begin errors++; $display("FAIL reserve_2_4_6 got %h want 00000254", busy); end
    cycle(0, 1, 4, 32'h55, 0, 0, 0, 0, 1);
    checks += 1;
    if (busy !== 32'h0) begin errors++; $display("FAIL flush_busy got %h want 0", busy); end
    cycle(0, 0, 0, 0, 4, 0, 0, 0, 0);
    checks += 1;
    if (rd0Val !== 32'h55) begin errors++; $display("FAIL flush_write_commits got %h want 00000055", rd0Val); end
  endtask

  task automatic test_reset_write();
    cycle(0, 1, 1, 32'h11, 0, 0, 1, 1, 0);
    checks += 1;
    if (busy[1] !== 1'b1) begin errors++; $display("FAIL pre_reset_busy1 got %b want 1", busy[1]); end
    cycle(1, 1, 1, 32'hFF, 0, 0, 0, 0, 0);
    checks += 1;
    if (busy !== 32'h0) begin errors++; $display("FAIL reset_clears_busy got %h want 0", busy); end
    cycle(0, 0, 0, 0, 1, 1, 0, 0, 0);
    checks += 2;
    if (rd0Val !== 32'h0) begin errors++; $display("FAIL reset_drops_write got %h want 0", rd0Val); end
    if (rd1Val !== 32'h0) begin errors++; $display("FAIL reset_clears_x1 got %h want 0", rd1Val); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic        r, we, re, fl;
      logic [4:0]  wa, a0, a1, ra;
      logic [31:0] wv;
      r  = ($urandom_range(0, 63) == 0);
      fl = ($urandom_range(0, 15) == 0);
      we = $urandom_range(0, 1) == 1;
      re = $urandom_range(0, 1) == 1;
      wa = 5'($urandom_range(0, 31));
      ra = 5'($urandom_range(0, 31));
      wv = $urandom;
      // Bias reads toward the write address to exercise forwarding.
      a0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      cycle(r, we, wa, wv, a0, a1, re, ra, fl);
      checks += 3;
      if (rd0Val !== m_rd0) begin errors++; $display("FAIL rand_rd0 n=%0d got %h want %h", n, rd0Val, m_rd0); end
      if (rd1Val !== m_rd1) begin errors++; $display("FAIL rand_rd1 n=%0d got %h want %h", n, rd1Val, m_rd1); end
      if (busy !== m_busy)  begin errors++; $display("FAIL rand_busy n=%0d got %h want %h", n, busy, m_busy); end
    end
  endtask

  initial begin
    rst = 1'b1; wr.en = 1'b0; wr.addr = '0; wr.val = '0;
    rd0Addr = '0; rd1Addr = '0; rsvEn = 1'b0; rsvAddr = '0; flush = 1'b0;
    #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_flush();
    test_reset_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
